pc_ctrl: RTL and testbench



---
 rtl/pc_ctrl.sv | 121 ++++++++++++
 tb/tb_pc_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter register and fetch sequencer: reset-vector load, interrupt entry, jumps and returns.
// Define PC_CTRL_NESTED_INT_EN to accept irq while already inside an ISR.
module pc_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         jump_en,
  input  logic         ret_en,
  input  logic         irq,
  input  logic [W-1:0] pc_in,
  output logic [W-1:0] pc,
  output logic [1:0]   pc_src,
  output logic         vec_rd,
  output logic         vec_addr,
  output logic         push_en,
  output logic [W-1:0] push_data,
  output logic         int_ack,
  output logic         flush
);

  localparam logic [1:0] SRC_RST = 2'b00;
  localparam logic [1:0] SRC_INT = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;
  localparam logic [1:0] SRC_STK = 2'b11;

  typedef enum logic [2:0] {
    RST_VEC,
    RST_LOAD,
    RUN,
    INT_PUSH,
    INT_LOAD
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] pc_nxt;
  logic         in_isr, in_isr_nxt;
  logic         irq_ok;

`ifdef PC_CTRL_NESTED_INT_EN
  assign irq_ok = irq & ~stall;
`else
  assign irq_ok = irq & ~in_isr & ~stall;
`endif

  // State, PC and ISR flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RST_VEC;
      pc     <= '0;
      in_isr <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      in_isr <= in_isr_nxt;
    end
  end

  // Next-state and control outputs; everything is held at zero during reset
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    in_isr_nxt = in_isr;
    pc_src     = SRC_RST;
    vec_rd     = 1'b0;
    vec_addr   = 1'b0;
    push_en    = 1'b0;
    push_data  = '0;
    int_ack    = 1'b0;
    flush      = 1'b0;
    if (!rst) begin
      push_data = pc;
      case (state)
        RST_VEC: begin
          vec_rd    = 1'b1;
          vec_addr  = 1'b0;
          state_nxt = RST_LOAD;
        end
        RST_LOAD: begin
          pc_src    = SRC_RST;
          pc_nxt    = pc_in;
          flush     = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          pc_src = SRC_REG;
          if (ret_en) begin
            pc_src     = SRC_STK;
            pc_nxt     = pc_in;
            flush      = 1'b1;
            in_isr_nxt = 1'b0;
          end else if (jump_en) begin
            pc_nxt = pc_in;
            flush  = 1'b1;
          end else if (irq_ok) begin
            state_nxt = INT_PUSH;
          end else if (!stall) begin
            pc_nxt = pc + W'(1);
          end
        end
        INT_PUSH: begin
          push_en    = 1'b1;
          int_ack    = 1'b1;
          vec_rd     = 1'b1;
          vec_addr   = 1'b1;
          in_isr_nxt = 1'b1;
          state_nxt  = INT_LOAD;
        end
        INT_LOAD: begin
          pc_src    = SRC_INT;
          pc_nxt    = pc_in;
          flush     = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RST_VEC;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed per-cycle expectations queued by stimulus, checked by a monitor.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst, stall, jump_en, ret_en, irq;
  logic [7:0] pc_in, pc, push_data;
  logic [1:0] pc_src;
  logic       vec_rd, vec_addr, push_en, int_ack, flush;

  // Environment: vector memory with synchronous read, register and stack sources, PC input mux
  logic [7:0] mem [2];
  logic [7:0] vec_q = 8'h00;
  logic [7:0] rb_val, stk_val;

  always #5 clk = ~clk;

  always @(posedge clk) if (vec_rd) vec_q <= mem[vec_addr];

  assign pc_in = (pc_src == 2'b10) ? rb_val :
                 (pc_src == 2'b11) ? stk_val : vec_q;

  pc_ctrl #(.W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en), .ret_en(ret_en),
    .irq(irq), .pc_in(pc_in), .pc(pc), .pc_src(pc_src), .vec_rd(vec_rd),
    .vec_addr(vec_addr), .push_en(push_en), .push_data(push_data),
    .int_ack(int_ack), .flush(flush)
  );

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [1:0] src;
    bit         chk_src;
    logic       vr, va, pe, ack, fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: compare outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      bit   ok;
      e  = q.pop_front();
      ok = (pc === e.pc) && (!e.chk_src || pc_src === e.src) &&
           (vec_rd === e.vr) && (vec_addr === e.va) && (push_en === e.pe) &&
           (!e.pe || push_data === e.pc) && (int_ack === e.ack) && (flush === e.fl);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s: got pc=%h src=%b vr=%b va=%b pe=%b pd=%h ack=%b fl=%b; want pc=%h src=%b(chk=%0d) vr=%b va=%b pe=%b pd=%h ack=%b fl=%b",
                 e.name, pc, pc_src, vec_rd, vec_addr, push_en, push_data, int_ack, flush,
                 e.pc, e.src, e.chk_src, e.vr, e.va, e.pe, e.pc, e.ack, e.fl);
      end
    end
  end

  // Queue the expected outputs for the current cycle, then advance one clock
  task automatic cyc(input string nm, input logic [7:0] epc, input logic [1:0] esrc,
                     input bit chk, input logic vr, input logic va, input logic pe,
                     input logic ack, input logic fl);
    exp_t e;
    e.name = nm; e.pc = epc; e.src = esrc; e.chk_src = chk;
    e.vr = vr; e.va = va; e.pe = pe; e.ack = ack; e.fl = fl;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic j, input logic rt,
                       input logic i, input logic [7:0] rb, input logic [7:0] stk);
    rst = r; stall = s; jump_en = j; ret_en = rt; irq = i; rb_val = rb; stk_val = stk;
  endtask

  initial begin
    mem[0] = 8'h20;
    mem[1] = 8'h80;
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk); #1;
    // reset held for a second cycle: outputs forced low
    cyc("rst_hold",     8'h00, 2'b00, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("rst_vec",      8'h00, 2'b00, 0, 1, 0, 0, 0, 0);
    cyc("rst_load",     8'h00, 2'b00, 1, 0, 0, 0, 0, 1);
    cyc("run_m0",       8'h20, 2'b10, 1, 0, 0, 0, 0, 0);
    cyc("inc_21",       8'h21, 2'b10, 1, 0, 0, 0, 0, 0);
    // jump to 0xFE then wrap
    drive(0, 0, 1, 0, 0, 8'hFE, 8'h00);
    cyc("jump_fe",      8'h22, 2'b10, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("pc_fe",        8'hFE, 2'b10, 1, 0, 0, 0, 0, 0);
    cyc("pc_ff",        8'hFF, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 8'h00, 8'h00);
    cyc("wrap_00",      8'h00, 2'b10, 1, 0, 0, 0, 0, 0);
    cyc("stall_2",      8'h00, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h00, 8'h00);
    cyc("stall_irq",    8'h00, 2'b10, 1, 0, 0, 0, 0, 0);
    // jump overrides stall
    drive(0, 1, 1, 0, 0, 8'h40, 8'h00);
    cyc("jump_stall",   8'h00, 2'b10, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("pc_40",        8'h40, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 8'h35, 8'h00);
    cyc("jump_35",      8'h41, 2'b10, 1, 0, 0, 0, 0, 1);
    // interrupt entry
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("irq_sample",   8'h35, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("int_push",     8'h35, 2'b00, 0, 1, 1, 1, 1, 0);
    cyc("int_load",     8'h35, 2'b01, 1, 0, 0, 0, 0, 1);
    // irq masked inside ISR
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("isr_mask1",    8'h80, 2'b10, 1, 0, 0, 0, 0, 0);
    cyc("isr_mask2",    8'h81, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h35);
    cyc("ret_35",       8'h82, 2'b11, 1, 0, 0, 0, 0, 1);
    // in_isr cleared: irq accepted again
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("irq_again",    8'h35, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("int_push2",    8'h35, 2'b00, 0, 1, 1, 1, 1, 0);
    cyc("int_load2",    8'h35, 2'b01, 1, 0, 0, 0, 0, 1);
    // ret beats jump beats irq
    drive(0, 0, 1, 1, 1, 8'h10, 8'h50);
    cyc("simul",        8'h80, 2'b11, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("simul_irq",    8'h50, 2'b10, 1, 0, 0, 0, 0, 0);
    // INT_PUSH ignores jump and stall
    drive(0, 1, 1, 0, 1, 8'h11, 8'h00);
    cyc("push_ign",     8'h50, 2'b00, 0, 1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("load_ign",     8'h50, 2'b01, 1, 0, 0, 0, 0, 1);
    // reset during INT_PUSH
    drive(0, 0, 0, 1, 0, 8'h00, 8'h60);
    cyc("ret_60",       8'h80, 2'b11, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("irq_60",       8'h60, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("rst_in_push",  8'h60, 2'b00, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("re_rst_vec",   8'h00, 2'b00, 0, 1, 0, 0, 0, 0);
    cyc("re_rst_load",  8'h00, 2'b00, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
    cyc("post_rst_irq", 8'h20, 2'b10, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc("post_push",    8'h20, 2'b00, 0, 1, 1, 1, 1, 0);
    cyc("post_load",    8'h20, 2'b01, 1, 0, 0, 0, 0, 1);
    cyc("final_80",     8'h80, 2'b10, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
